// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point helpers for the neural-network layer stages:
// FSM state encoding, saturation limits and round/shift/saturate.
package nn_fixed_pkg;

  localparam int unsigned WIDE        = 64;
  localparam int unsigned SHIFT_WIDTH = 4;
  localparam int unsigned POINT_WIDTH = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_BIAS,
    ST_REQ
  } state_t;

  function automatic logic signed [WIDE-1:0] sat_max(input int unsigned width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [WIDE-1:0] sat_min(input int unsigned width);
    return -(64'sd1 <<< (width - 1));
  endfunction

  // Round-half-up arithmetic right shift, then clamp to a signed width-bit range.
  function automatic logic signed [WIDE-1:0] sat_round(
    input logic signed [WIDE-1:0]        acc,
    input logic        [SHIFT_WIDTH-1:0] shift,
    input int unsigned                   width
  );
    logic signed [WIDE-1:0] rnd;
    logic signed [WIDE-1:0] r;
    rnd = (shift != 4'd0) ? (64'sd1 <<< (shift - 4'd1)) : 64'sd0;
    r   = (acc + rnd) >>> shift;
    if (r > sat_max(width)) begin
      r = sat_max(width);
    end else if (r < sat_min(width)) begin
      r = sat_min(width);
    end
    return r;
  endfunction

endpackage

// File: rtl/requant_sat.sv
// Combinational requantisation: round, arithmetic shift and saturate an
// accumulator down to DATA_WIDTH.
module requant_sat
  import nn_fixed_pkg::*;
#(
  parameter int unsigned ACC_WIDTH  = 24,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic signed [ACC_WIDTH-1:0]   acc,
  input  logic        [SHIFT_WIDTH-1:0] shift,
  output logic signed [DATA_WIDTH-1:0]  res_c
);

  always_comb begin
    res_c = DATA_WIDTH'(sat_round(WIDE'(acc), shift, DATA_WIDTH));
  end

endmodule

// File: rtl/neuron_mac.sv
// Neuron pre-activation: streamed signed dot product plus bias, requantised
// and saturated, handed to the activation stage with a one-cycle valid.
module neuron_mac
  import nn_fixed_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 5,
  parameter int unsigned ACC_WIDTH  = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CNT_WIDTH-1:0]    n_inputs,
  input  logic [3:0]              shift,
  input  logic [2:0]              point,
  input  logic [2*DATA_WIDTH-1:0] bias,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   x_in,
  input  logic [DATA_WIDTH-1:0]   w_in,
  output logic                    busy,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   act_out,
  output logic [2:0]              point_out
);

  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

  if (ACC_WIDTH < 2 * DATA_WIDTH + CNT_WIDTH) begin : g_acc_width_check
    $error("neuron_mac: ACC_WIDTH too small for worst-case dot product");
  end

  state_t                        state_q, state_d;
  logic [CNT_WIDTH-1:0]          cnt_q, n_lat_q;
  logic [SHIFT_WIDTH-1:0]        shift_q;
  logic [POINT_WIDTH-1:0]        point_q;
  logic signed [PROD_WIDTH-1:0]  bias_q, prod_r;
  logic                          prod_v;
  logic signed [ACC_WIDTH-1:0]   acc_q;
  logic signed [PROD_WIDTH-1:0]  prod_c;
  logic signed [DATA_WIDTH-1:0]  req_c;
  logic                          accept_c, start_ok_c, last_beat_c;

  assign accept_c = in_valid && in_ready;
  assign prod_c   = PROD_WIDTH'($signed(x_in)) * PROD_WIDTH'($signed(w_in));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state; a start coinciding with out_valid belongs to the finishing run
  always_comb begin
    state_d     = state_q;
    start_ok_c  = 1'b0;
    last_beat_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !out_valid) begin
          start_ok_c = 1'b1;
          state_d    = (n_inputs != '0) ? ST_ACCUM : ST_BIAS;
        end
      end
      ST_ACCUM: begin
        if (accept_c && ((cnt_q + CNT_WIDTH'(1)) == n_lat_q)) begin
          last_beat_c = 1'b1;
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_BIAS;
      ST_BIAS:  state_d = ST_REQ;
      ST_REQ:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  requant_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_requant_sat (
    .acc  (acc_q),
    .shift(shift_q),
    .res_c(req_c)
  );

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      n_lat_q   <= '0;
      shift_q   <= '0;
      point_q   <= '0;
      bias_q    <= '0;
      prod_r    <= '0;
      prod_v    <= 1'b0;
      acc_q     <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      act_out   <= '0;
      point_out <= '0;
    end else begin
      prod_v    <= accept_c;
      out_valid <= (state_q == ST_REQ);
      if (accept_c) prod_r <= prod_c;

      if (start_ok_c) begin
        acc_q <= '0;
      end else begin
        acc_q <= acc_q
               + (prod_v ? ACC_WIDTH'(prod_r) : '0)
               + ((state_q == ST_BIAS) ? ACC_WIDTH'(bias_q) : '0);
      end

      if (start_ok_c) begin
        n_lat_q  <= n_inputs;
        shift_q  <= shift;
        point_q  <= point;
        bias_q   <= bias;
        cnt_q    <= '0;
        busy     <= 1'b1;
        in_ready <= (n_inputs != '0);
      end else if (accept_c) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
        if (last_beat_c) in_ready <= 1'b0;
      end

      if (state_q == ST_REQ) begin
        act_out   <= req_c;
        point_out <= point_q;
        busy      <= 1'b0;
      end
    end
  end

endmodule
